// File: rtl/io_1_serial_tx.sv
// Framed serial transmitter for the W_IO pad: start bit, LSB-first data, optional even parity,
// stop bit. Drives the pad only during a frame and flags pad readback mismatches.
module io_1_serial_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned PARITY = 0
) (
  input  logic             UserCLK,
  input  logic             UserRSTn,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  output logic             BUSY,
  output logic             COLLISION,
  output logic             I_top,
  output logic             T_top,
  input  logic             O_top
);

  localparam int unsigned DivW = $clog2(CLKDIV);
  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLKDIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             coll_q, coll_d;
  logic             o_q;
  logic             bit_end;

  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      coll_q  <= 1'b0;
      o_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      coll_q  <= coll_d;
      o_q     <= O_top;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    coll_d  = coll_q;
    I_top   = 1'b1;
    T_top   = 1'b1;
    READY   = 1'b0;
    bit_end = (div_q == DivLast);

    unique case (state_q)
      StIdle: begin
        T_top = 1'b0;
        READY = 1'b1;
      end
      StStart: I_top = 1'b0;
      StData:  I_top = shift_q[0];
      StPar:   I_top = par_q;
      StStop:  I_top = 1'b1;
      default: ;
    endcase

    if (state_q == StIdle) begin
      div_d = '0;
      if (VALID) begin
        shift_d = D;
        par_d   = ^D;
        coll_d  = 1'b0;
        bit_d   = '0;
        state_d = StStart;
      end
    end else begin
      div_d = bit_end ? '0 : div_q + 1'b1;
      // o_q lags the pad by one cycle, so compare only once the bit has settled
      if (bit_end && (o_q != I_top)) begin
        coll_d = 1'b1;
      end
      if (bit_end) begin
        unique case (state_q)
          StStart: state_d = StData;
          StData: begin
            shift_d = shift_q >> 1;
            if (bit_q == BitLast) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? StPar : StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          StPar:   state_d = StStop;
          StStop:  state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  assign BUSY      = T_top;
  assign COLLISION = coll_q;

endmodule

// File: tb/tb_io_1_serial_tx.sv
// Bench for io_1_serial_tx: two instances (no parity / even parity) checked every cycle
// against a frame-level model, plus directed scenarios with literal expectations.
module tb_io_1_serial_tx;

  logic       UserCLK;
  logic       UserRSTn;
  logic [1:0] valid;
  logic [7:0] d [2];
  logic [1:0] force_lo;
  logic       chk_en;

  wire [1:0] ready, busy, coll, i_top, t_top;
  wire [1:0] o_top = i_top & ~force_lo;

  int checks   = 0;
  int failures = 0;

  io_1_serial_tx #(.WIDTH(8), .CLKDIV(4), .PARITY(0)) u_dut0 (
    .UserCLK  (UserCLK),
    .UserRSTn (UserRSTn),
    .D        (d[0]),
    .VALID    (valid[0]),
    .READY    (ready[0]),
    .BUSY     (busy[0]),
    .COLLISION(coll[0]),
    .I_top    (i_top[0]),
    .T_top    (t_top[0]),
    .O_top    (o_top[0])
  );

  io_1_serial_tx #(.WIDTH(8), .CLKDIV(4), .PARITY(1)) u_dut1 (
    .UserCLK  (UserCLK),
    .UserRSTn (UserRSTn),
    .D        (d[1]),
    .VALID    (valid[1]),
    .READY    (ready[1]),
    .BUSY     (busy[1]),
    .COLLISION(coll[1]),
    .I_top    (i_top[1]),
    .T_top    (t_top[1]),
    .O_top    (o_top[1])
  );

  initial begin
    UserCLK = 1'b0;
    forever #5 UserCLK = ~UserCLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: bit index = cycles since accept / CLKDIV.
  function automatic int flen(input int u);
    return (10 + u) * 4;
  endfunction

  function automatic logic exp_bit(input int u, input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (u == 1 && idx == 9) return ^w;
    return 1'b1;
  endfunction

  logic       m_busy [2];
  int         m_t    [2];
  logic       m_coll [2];
  logic       m_oq   [2];
  logic [7:0] m_word [2];

  always @(posedge UserCLK or negedge UserRSTn) begin
    for (int u = 0; u < 2; u++) begin
      if (!UserRSTn) begin
        m_busy[u] <= 1'b0;
        m_t[u]    <= 0;
        m_coll[u] <= 1'b0;
        m_oq[u]   <= 1'b1;
      end else begin
        if (m_busy[u]) begin
          if (m_t[u] % 4 == 3 && m_oq[u] != exp_bit(u, m_word[u], m_t[u] / 4)) m_coll[u] <= 1'b1;
          if (m_t[u] == flen(u) - 1) m_busy[u] <= 1'b0;
          else m_t[u] <= m_t[u] + 1;
        end else if (valid[u]) begin
          m_word[u] <= d[u];
          m_busy[u] <= 1'b1;
          m_t[u]    <= 0;
          m_coll[u] <= 1'b0;
        end
        m_oq[u] <= o_top[u];
      end
    end
  end

  always @(negedge UserCLK) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        logic ei;
        ei = m_busy[u] ? exp_bit(u, m_word[u], m_t[u] / 4) : 1'b1;
        check($sformatf("u%0d i_top", u), 32'(i_top[u]), 32'(ei));
        check($sformatf("u%0d t_top", u), 32'(t_top[u]), 32'(m_busy[u]));
        check($sformatf("u%0d busy", u), 32'(busy[u]), 32'(m_busy[u]));
        check($sformatf("u%0d ready", u), 32'(ready[u]), 32'(!m_busy[u]));
        check($sformatf("u%0d collision", u), 32'(coll[u]), 32'(m_coll[u]));
      end
    end
  end

  // Offer one word; returns at the negedge inside cycle 0 of the frame.
  task automatic send(input int u, input logic [7:0] w);
    @(negedge UserCLK);
    valid[u] = 1'b1;
    d[u]     = w;
    @(negedge UserCLK);
    valid[u] = 1'b0;
  endtask

  // Sample mid-bit pad levels and count driven cycles; optionally force the pad low from bit
  // force_bit onward, or pulse VALID with 0x55 at cycle pulse_t.
  task automatic capture(input int u, input int force_bit, input int pulse_t,
                         output logic [11:0] bits, output int tlen);
    int nb;
    nb   = 10 + u;
    tlen = 0;
    bits = '1;
    for (int t = 0; t < nb * 4 + 2; t++) begin
      if (t > 0) @(negedge UserCLK);
      force_lo[u] = (force_bit >= 0) && (t >= force_bit * 4) && (t < nb * 4);
      if (t == pulse_t) begin
        valid[u] = 1'b1;
        d[u]     = 8'h55;
      end else if (t == pulse_t + 1) begin
        valid[u] = 1'b0;
      end
      if (t_top[u]) tlen++;
      if (t % 4 == 1 && t / 4 < nb) bits[t/4] = i_top[u];
    end
    force_lo[u] = 1'b0;
  endtask

  logic [11:0] bits;
  int          tlen;
  int          n;
  int          gap;

  initial begin
    UserRSTn = 1'b0;
    valid    = '0;
    d[0]     = '0;
    d[1]     = '0;
    force_lo = '0;
    chk_en   = 1'b0;
    repeat (3) @(negedge UserCLK);
    check("reset i_top", 32'(i_top), 32'h3);
    check("reset t_top", 32'(t_top), 32'h0);
    check("reset ready", 32'(ready), 32'h3);
    check("reset busy", 32'(busy), 32'h0);
    check("reset collision", 32'(coll), 32'h0);
    UserRSTn = 1'b1;
    chk_en   = 1'b1;

    // Basic frame
    send(0, 8'hA5);
    capture(0, -1, -1, bits, tlen);
    check("basic bits", 32'(bits[9:0]), 32'h34A);
    check("basic length", 32'(tlen), 32'd40);
    check("basic collision", 32'(coll[0]), 32'h0);

    // Parity
    send(1, 8'h07);
    capture(1, -1, -1, bits, tlen);
    check("par07 bits", 32'(bits[10:0]), 32'h60E);
    check("par07 parity", 32'(bits[9]), 32'h1);
    check("par07 length", 32'(tlen), 32'd44);
    send(1, 8'h03);
    capture(1, -1, -1, bits, tlen);
    check("par03 bits", 32'(bits[10:0]), 32'h406);
    check("par03 parity", 32'(bits[9]), 32'h0);

    // Back-to-back with VALID held
    @(negedge UserCLK);
    valid[0] = 1'b1;
    d[0]     = 8'h01;
    @(negedge UserCLK);
    d[0] = 8'hFF;
    n    = 0;
    gap  = 0;
    while (t_top[0] && n < 100) begin
      @(negedge UserCLK);
      n++;
    end
    while (!t_top[0] && n < 100) begin
      @(negedge UserCLK);
      gap++;
      n++;
    end
    valid[0] = 1'b0;
    check("b2b within bound", 32'(n < 100), 32'h1);
    check("b2b gap", 32'(gap), 32'd1);
    capture(0, -1, -1, bits, tlen);
    check("b2b second word", 32'(bits[9:0]), 32'h3FE);

    // VALID while busy is ignored
    send(0, 8'hA5);
    capture(0, -1, 10, bits, tlen);
    check("ignore bits", 32'(bits[9:0]), 32'h34A);
    n = 0;
    repeat (6) begin
      @(negedge UserCLK);
      if (t_top[0]) n++;
    end
    check("ignore no second frame", 32'(n), 32'd0);

    // Collision on stop bit, sticky, cleared on next accept
    send(0, 8'h00);
    capture(0, 9, -1, bits, tlen);
    check("collision set", 32'(coll[0]), 32'h1);
    repeat (3) @(negedge UserCLK);
    check("collision sticky idle", 32'(coll[0]), 32'h1);
    send(0, 8'h00);
    check("collision cleared on accept", 32'(coll[0]), 32'h0);
    capture(0, -1, -1, bits, tlen);
    check("collision clean frame", 32'(coll[0]), 32'h0);
    check("zero word bits", 32'(bits[9:0]), 32'h200);

    // Reset mid-frame during data bit 3
    send(0, 8'hFF);
    repeat (17) @(negedge UserCLK);
    #1 UserRSTn = 1'b0;
    #1;
    check("midreset i_top", 32'(i_top[0]), 32'h1);
    check("midreset t_top", 32'(t_top[0]), 32'h0);
    check("midreset ready", 32'(ready[0]), 32'h1);
    @(negedge UserCLK);
    UserRSTn = 1'b1;
    valid[0] = 1'b1;
    d[0]     = 8'h3C;
    @(negedge UserCLK);
    valid[0] = 1'b0;
    capture(0, -1, -1, bits, tlen);
    check("post-reset bits", 32'(bits[9:0]), 32'h278);
    check("post-reset length", 32'(tlen), 32'd40);

    repeat (2) @(negedge UserCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
